// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ranger: drives the trigger pulse, then times the echo high width in clocks.
// Optional auto-retrigger is compiled in with ULTRASONIC_AUTO_TRIGGER_EN.
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int PERIOD_CYCLES  = 6000000,
  parameter int CNT_W          = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             echo_in,
  output logic             trig_out,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] echo_cycles
);

  localparam int                TRIG_W    = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  if ((TRIG_CYCLES < 1) ||
      (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) ||
      (PERIOD_CYCLES <= TRIG_CYCLES + TIMEOUT_CYCLES + 4)) begin : g_bad_cfg
    $error("ultrasonic_ranger: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE
`ifdef ULTRASONIC_AUTO_TRIGGER_EN
    , S_WAIT_PERIOD
`endif
  } state_t;

  state_t            r_state, w_next;
  logic              r_sync1, r_echo_s, r_echo_d;
  logic              w_rise, w_fall, w_to_hit, w_to_fail, w_accept, w_timing;
  logic [TRIG_W-1:0] r_trig_cnt;
  logic [CNT_W-1:0]  r_tcnt, r_width, r_result;
  logic              r_trig, r_busy, r_done, r_timeout;

  // echo_in is asynchronous: two flops to resolve metastability, a third for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_echo_s <= 1'b0;
      r_echo_d <= 1'b0;
    end else begin
      r_sync1  <= echo_in;
      r_echo_s <= r_sync1;
      r_echo_d <= r_echo_s;
    end
  end

  assign w_rise   = r_echo_s & ~r_echo_d;
  assign w_fall   = ~r_echo_s & r_echo_d;
  assign w_timing = (r_state == S_WAIT_RISE) || (r_state == S_MEASURE);
  assign w_to_hit = (r_tcnt == TO_LAST);
  // a falling edge on the last allowed cycle still yields a valid measurement
  assign w_to_fail = w_timing && w_to_hit && !((r_state == S_MEASURE) && w_fall);

`ifdef ULTRASONIC_AUTO_TRIGGER_EN
  localparam int               PER_W    = $clog2(PERIOD_CYCLES + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
  logic [PER_W-1:0] r_pcnt;
  logic             w_period_hit;

  // counts from the cycle after a trigger is accepted; saturates so the hit is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_pcnt <= '0;
    else if (w_accept)          r_pcnt <= '0;
    else if (r_pcnt < PER_LAST) r_pcnt <= r_pcnt + 1'b1;
  end
  assign w_period_hit = (r_pcnt >= PER_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_TRIG;
      S_TRIG:      if (r_trig_cnt == '0) w_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (w_to_hit)    w_next = S_DONE;
        else if (w_rise) w_next = S_MEASURE;
      end
      S_MEASURE:   if (w_fall || w_to_hit) w_next = S_DONE;
`ifdef ULTRASONIC_AUTO_TRIGGER_EN
      S_DONE:        w_next = S_WAIT_PERIOD;
      S_WAIT_PERIOD: if (start || w_period_hit) w_next = S_TRIG;
`else
      S_DONE:        w_next = S_IDLE;
`endif
      default:     w_next = S_IDLE;
    endcase
  end

  assign w_accept = (w_next == S_TRIG) && (r_state != S_TRIG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_trig_cnt <= '0;
    else if (w_accept)                              r_trig_cnt <= TRIG_LAST;
    else if (r_state == S_TRIG && r_trig_cnt != '0) r_trig_cnt <= r_trig_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt   <= '0;
      r_width  <= '0;
      r_result <= '0;
    end else begin
      if (r_state == S_TRIG) r_tcnt <= '0;
      else if (w_timing)     r_tcnt <= r_tcnt + 1'b1;

      if (r_state == S_WAIT_RISE && w_rise)        r_width <= CNT_W'(1);
      else if (r_state == S_MEASURE && r_echo_s)   r_width <= r_width + 1'b1;

      if (r_state == S_MEASURE && w_fall) r_result <= r_width;
      else if (w_to_fail)                 r_result <= '0;
    end
  end

  // outputs registered from the next state so the sensor pin never sees decode glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_trig    <= (w_next == S_TRIG);
      r_busy    <= (w_next == S_TRIG) || (w_next == S_WAIT_RISE) || (w_next == S_MEASURE);
      r_done    <= (w_next == S_DONE);
      r_timeout <= w_to_fail;
    end
  end

  assign trig_out    = r_trig;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign echo_cycles = r_result;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Randomized scoreboard bench for ultrasonic_ranger; define ULTRASONIC_AUTO_TRIGGER_EN
// for the auto-retrigger run.
module tb_ultrasonic_ranger;
  localparam int TRIG    = 4;
  localparam int TIMEOUT = 50;
  localparam int PERIOD  = 100;
  localparam int CW      = 8;

  logic          clk = 1'b0;
  logic          rst, start, echo_in;
  logic          trig_out, busy, done, timeout;
  logic [CW-1:0] echo_cycles;

  ultrasonic_ranger #(
    .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TIMEOUT), .PERIOD_CYCLES(PERIOD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .echo_in(echo_in),
    .trig_out(trig_out), .busy(busy), .done(done), .timeout(timeout),
    .echo_cycles(echo_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { bit to; int val; int at; } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0, fails = 0;
  int   n_rise = 0, exp_rise = 0;
  logic trig_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every done is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (trig_out && !trig_prev) n_rise++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.at);
          chk("timeout_flag", int'(timeout), int'(e.to));
          chk("echo_cycles", int'(echo_cycles), e.val);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
    trig_prev = trig_out;
  end

  // Reference: with the echo rising r cycles and falling f=r+h cycles after trig falls,
  // the result appears 3 cycles after the raw fall, provided that is within TIMEOUT
  // cycles of trig falling; otherwise done/timeout fire exactly TIMEOUT cycles after.
  task automatic run_meas(input int r, input int h, input bit extra, input bit stuck);
    int k, t0, f, at, v;
    bit to;
    exp_t e;
    if (stuck) echo_in = 1'b1;
    tick();
    start = 1'b1;
    k = cyc;
    tick();
    start = 1'b0;
    exp_rise++;
    t0 = k + 1 + TRIG;
    f  = r + h;
    if (!stuck && f + 3 <= TIMEOUT) begin to = 1'b0; v = h; at = t0 + f + 3; end
    else                            begin to = 1'b1; v = 0; at = t0 + TIMEOUT; end
    e.to = to; e.val = v; e.at = at;
    sb.push_back(e);
    for (int i = 0; i < TRIG; i++) begin
      chk("trig_high", int'(trig_out), 1);
      chk("busy_high", int'(busy), 1);
      tick();
    end
    chk("trig_low", int'(trig_out), 0);
    if (stuck) begin
      repeat (TIMEOUT + 2) tick();
      echo_in = 1'b0;
    end else begin
      repeat (r) tick();
      echo_in = 1'b1;
      for (int i = 0; i < h; i++) begin
        if (extra && i == h - 1) start = 1'b1;
        tick();
        start = 1'b0;
      end
      echo_in = 1'b0;
    end
    while (cyc < at + 2) tick();
    chk("echo_hold", int'(echo_cycles), v);
    chk("busy_idle", int'(busy), 0);
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; echo_in = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_trig", int'(trig_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_echo_cycles", int'(echo_cycles), 0);
    rst = 1'b0;
    repeat (5) tick();

`ifdef ULTRASONIC_AUTO_TRIGGER_EN
    begin
      int last, n, t0;
      exp_t e;
      last = 0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int p = 0; p < 3; p++) begin
        n = 0;
        while (!trig_out && n < 150) begin tick(); n++; end
        chk("trig_seen", int'(trig_out), 1);
        if (!trig_out) break;
        exp_rise++;
        if (p > 0) chk("period", cyc - last, PERIOD);
        last = cyc;
        n = 0;
        while (trig_out && n < 20) begin tick(); n++; end
        t0 = cyc;
        e.to = 1'b0; e.val = 10; e.at = t0 + 16;
        sb.push_back(e);
        repeat (3) tick();
        echo_in = 1'b1;
        repeat (10) tick();
        echo_in = 1'b0;
      end
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
`else
    run_meas(5, 20, 1'b0, 1'b0);
    run_meas(60, 0, 1'b0, 1'b0);
    run_meas(0, 0, 1'b0, 1'b1);
    run_meas(5, 20, 1'b1, 1'b0);
    run_meas(7, 40, 1'b0, 1'b0);
    run_meas(8, 40, 1'b0, 1'b0);

    // asynchronous reset in the second trigger cycle
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_rise++;
    chk("trig_first", int'(trig_out), 1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_trig", int'(trig_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_echo_cycles", int'(echo_cycles), 0);
    run_meas(5, 20, 1'b0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      int r, h;
      bit ex;
      r  = int'($urandom_range(0, 25));
      h  = int'($urandom_range(1, 45));
      ex = (r + h + 3 <= TIMEOUT) && (h >= 4) && ($urandom_range(0, 1) == 1);
      run_meas(r, h, ex, 1'b0);
    end
`endif

    repeat (5) tick();
    chk("sb_drained", sb.size(), 0);
    chk("trig_pulses", n_rise, exp_rise);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
